// File: rtl/mem_stage_ctrl.sv
// Memory stage: drives a variable-latency data memory via req/done,
// stalls upstream while an access is outstanding, and loads MEM/WB.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ALUO_EXMEM,
  input  logic [15:0] Rd2_EXMEM,
  input  logic [2:0]  WrR_EXMEM,
  input  logic        MemRead_EXMEM,
  input  logic        MemWrite_EXMEM,
  input  logic        MemtoReg_EXMEM,
  input  logic        RegWrite_EXMEM,
  input  logic        halt_EXMEM,
  input  logic        jumpAndLink_EXMEM,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic        stall_mem,
  output logic [15:0] ReadData_MEMWB,
  output logic [15:0] ALUO_MEMWB,
  output logic [2:0]  WrR_MEMWB,
  output logic        RegWrite_MEMWB,
  output logic        MemtoReg_MEMWB,
  output logic        halt_MEMWB,
  output logic        jumpAndLink_MEMWB,
  output logic        err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [15:0] rd_q, rd_d;
  logic [15:0] alu_q, alu_d;
  logic [2:0]  wrr_q, wrr_d;
  logic        rw_q, rw_d;
  logic        m2r_q, m2r_d;
  logic        halt_q, halt_d;
  logic        jal_q, jal_d;

  logic memop, mis, both, is_load, tmo;

  always_comb begin
    memop   = MemRead_EXMEM | MemWrite_EXMEM;
    mis     = memop & ALUO_EXMEM[0];
    both    = MemRead_EXMEM & MemWrite_EXMEM;
    is_load = MemRead_EXMEM & ~MemWrite_EXMEM;
    tmo     = (cnt_q == TMO);

    mem_wr    = MemWrite_EXMEM;
    mem_addr  = ALUO_EXMEM;
    mem_wdata = Rd2_EXMEM;
    mem_req   = 1'b0;
    stall_mem = 1'b0;

    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rd_d    = rd_q;
    alu_d   = alu_q;
    wrr_d   = wrr_q;
    rw_d    = rw_q;
    m2r_d   = m2r_q;
    halt_d  = halt_q;
    jal_d   = jal_q;

    unique case (state_q)
      S_IDLE: begin
        mem_req   = memop & ~mis & ~rst;
        stall_mem = mem_req;
        if (mis | both) err_d = 1'b1;
        if (mem_req) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        stall_mem = ~mem_done & ~tmo;
        if (mem_done) begin
          state_d = S_IDLE;
          if (is_load) rd_d = mem_rdata;
        end else if (tmo) begin
          state_d = S_IDLE;
          rd_d    = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase

    // A stalled cycle retires a bubble; data fields keep their values.
    if (stall_mem) begin
      rw_d   = 1'b0;
      m2r_d  = 1'b0;
      halt_d = 1'b0;
      jal_d  = 1'b0;
    end else begin
      alu_d  = ALUO_EXMEM;
      wrr_d  = WrR_EXMEM;
      rw_d   = RegWrite_EXMEM & ~mis;
      m2r_d  = MemtoReg_EXMEM & ~mis;
      halt_d = halt_EXMEM;
      jal_d  = jumpAndLink_EXMEM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rd_q    <= '0;
      alu_q   <= '0;
      wrr_q   <= '0;
      rw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      halt_q  <= 1'b0;
      jal_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      wrr_q   <= wrr_d;
      rw_q    <= rw_d;
      m2r_q   <= m2r_d;
      halt_q  <= halt_d;
      jal_q   <= jal_d;
    end
  end

  assign err               = err_q;
  assign ReadData_MEMWB    = rd_q;
  assign ALUO_MEMWB        = alu_q;
  assign WrR_MEMWB         = wrr_q;
  assign RegWrite_MEMWB    = rw_q;
  assign MemtoReg_MEMWB    = m2r_q;
  assign halt_MEMWB        = halt_q;
  assign jumpAndLink_MEMWB = jal_q;

endmodule
